// File: rtl/led_pkg.sv
// Shared types for the LED fade driver: per-channel ramp state encoding.
package led_pkg;

  typedef enum logic [1:0] {
    StOff      = 2'd0,
    StRampUp   = 2'd1,
    StOn       = 2'd2,
    StRampDown = 2'd3
  } led_state_e;

endpackage

// File: rtl/led_fade_ch.sv
// One LED channel: ramp state machine, brightness level and registered PWM pin.
module led_fade_ch #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                req,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                period_end,
  output logic                led_out,
  output logic                ramp_busy
);
  import led_pkg::*;

  localparam logic [PWM_BITS-1:0] LevelMax = '1;
  localparam logic [PWM_BITS:0]   MaxExt   = {1'b0, LevelMax};
  localparam logic [PWM_BITS:0]   StepExt  = (PWM_BITS + 1)'(RAMP_STEP);

  led_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;
  logic [PWM_BITS:0]   level_sum;

  // One extra bit so the increment can be checked for saturation.
  assign level_sum = {1'b0, level_q} + StepExt;

  // Next state and level; a direction change takes priority over a step.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      StOff: begin
        if (req) state_d = StRampUp;
      end
      StRampUp: begin
        if (!req) begin
          state_d = StRampDown;
        end else if (period_end) begin
          if (level_sum >= MaxExt) begin
            level_d = LevelMax;
            state_d = StOn;
          end else begin
            level_d = level_sum[PWM_BITS-1:0];
          end
        end
      end
      StOn: begin
        if (!req) state_d = StRampDown;
      end
      StRampDown: begin
        if (req) begin
          state_d = StRampUp;
        end else if (period_end) begin
          // Compare first so the subtraction never wraps.
          if ({1'b0, level_q} <= StepExt) begin
            level_d = '0;
            state_d = StOff;
          end else begin
            level_d = level_q - StepExt[PWM_BITS-1:0];
          end
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Pin value from the current state; fully on when ON, PWM compare while ramping.
  always_comb begin
    led_d = 1'b0;
    unique case (state_q)
      StOff:      led_d = 1'b0;
      StOn:       led_d = 1'b1;
      StRampUp,
      StRampDown: led_d = (pwm_cnt < level_q);
      default:    led_d = 1'b0;
    endcase
  end

  // State, level and output registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StOff;
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_out   = led_q;
  assign ramp_busy = (state_q == StRampUp) || (state_q == StRampDown);

endmodule

// File: rtl/led_fade_driver.sv
// Four-channel LED PWM driver with linear fades; shared prescaler and PWM counter.
module led_fade_driver #(
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [3:0] led_req,
  output logic [3:0] led_out,
  output logic [3:0] ramp_busy
);

  localparam int unsigned         PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0]     PreLast = PreW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PwmMax  = '1;

  logic [PreW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick;
  logic                period_end;

  assign tick       = (pre_cnt_q == PreLast);
  assign period_end = tick && (pwm_cnt_q == PwmMax);

  // Prescaler wraps at PRESCALE-1; PWM counter advances on tick and wraps naturally.
  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
  end

  // Shared counter registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    led_fade_ch #(
      .PWM_BITS  (PWM_BITS),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .pclk       (pclk),
      .presetn    (presetn),
      .req        (led_req[i]),
      .pwm_cnt    (pwm_cnt_q),
      .period_end (period_end),
      .led_out    (led_out[i]),
      .ramp_busy  (ramp_busy[i])
    );
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: two instances (PRESCALE 2 and 1) against a cycle-count model.
module tb_led_fade_driver;

  localparam int LMAX = 15;
  localparam int RS   = 5;

  typedef enum int {MOff, MUp, MOn, MDown} mphase_e;

  logic       clk;
  logic       presetn;
  logic [3:0] led_req_a, led_req_b;
  logic [3:0] led_out_a, led_out_b;
  logic [3:0] busy_a, busy_b;

  led_fade_driver #(.PRESCALE(2), .PWM_BITS(4), .RAMP_STEP(5)) dut_a (
    .pclk      (clk),
    .presetn   (presetn),
    .led_req   (led_req_a),
    .led_out   (led_out_a),
    .ramp_busy (busy_a)
  );

  led_fade_driver #(.PRESCALE(1), .PWM_BITS(4), .RAMP_STEP(5)) dut_b (
    .pclk      (clk),
    .presetn   (presetn),
    .led_req   (led_req_b),
    .led_out   (led_out_b),
    .ramp_busy (busy_b)
  );

  always #5 clk = ~clk;

  // Reference model: phase and level per channel; counters derived from cycles since reset.
  mphase_e     ph[2][4];
  int          lvl[2][4];
  int unsigned cyc[2];
  logic [3:0]  exp_led[2];
  int          n_tests, n_fail;
  logic [3:0]  cur_a, cur_b;
  int          highs;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cyc[d]     = 0;
      exp_led[d] = 4'b0;
      for (int i = 0; i < 4; i++) begin
        ph[d][i]  = MOff;
        lvl[d][i] = 0;
      end
    end
  endtask

  function automatic logic [3:0] exp_busy(input int d);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (ph[d][i] == MUp) || (ph[d][i] == MDown);
    return b;
  endfunction

  // Advance the model across one active edge, using the values seen just before it.
  task automatic model_edge(input logic [3:0] ra, input logic [3:0] rb);
    int pre, per, pwm;
    bit pe, r;
    for (int d = 0; d < 2; d++) begin
      pre = (d == 0) ? 2 : 1;
      per = pre * 16;
      pwm = (cyc[d] / pre) % 16;
      pe  = ((cyc[d] % per) == per - 1);
      for (int i = 0; i < 4; i++) begin
        r = (d == 0) ? ra[i] : rb[i];
        exp_led[d][i] = (ph[d][i] == MOn) ? 1'b1 :
                        (ph[d][i] == MOff) ? 1'b0 : (pwm < lvl[d][i]);
        case (ph[d][i])
          MOff: if (r) ph[d][i] = MUp;
          MUp: begin
            if (!r) ph[d][i] = MDown;
            else if (pe) begin
              lvl[d][i] = (lvl[d][i] + RS > LMAX) ? LMAX : lvl[d][i] + RS;
              if (lvl[d][i] == LMAX) ph[d][i] = MOn;
            end
          end
          MOn: if (!r) ph[d][i] = MDown;
          MDown: begin
            if (r) ph[d][i] = MUp;
            else if (pe) begin
              if (lvl[d][i] <= RS) begin
                lvl[d][i] = 0;
                ph[d][i]  = MOff;
              end else begin
                lvl[d][i] = lvl[d][i] - RS;
              end
            end
          end
          default: ph[d][i] = MOff;
        endcase
      end
      cyc[d]++;
    end
  endtask

  task automatic check_all();
    check_eq("led_out_a", {28'b0, led_out_a}, {28'b0, exp_led[0]});
    check_eq("led_out_b", {28'b0, led_out_b}, {28'b0, exp_led[1]});
    check_eq("busy_a", {28'b0, busy_a}, {28'b0, exp_busy(0)});
    check_eq("busy_b", {28'b0, busy_b}, {28'b0, exp_busy(1)});
  endtask

  // Drive requests, take one edge, update the model and compare 1 time unit later.
  task automatic step(input logic [3:0] ra, input logic [3:0] rb);
    led_req_a = ra;
    led_req_b = rb;
    cur_a     = ra;
    cur_b     = rb;
    @(posedge clk);
    if (presetn) model_edge(ra, rb);
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    presetn = 1'b0;
    #1;
    model_reset();
    check_eq({tag, "_led_a"}, {28'b0, led_out_a}, 32'd0);
    check_eq({tag, "_led_b"}, {28'b0, led_out_b}, 32'd0);
    check_eq({tag, "_busy_a"}, {28'b0, busy_a}, 32'd0);
    check_eq({tag, "_busy_b"}, {28'b0, busy_b}, 32'd0);
  endtask

  initial begin
    clk       = 1'b0;
    presetn   = 1'b0;
    led_req_a = 4'b0;
    led_req_b = 4'b0;
    cur_a     = 4'b0;
    cur_b     = 4'b0;
    n_tests   = 0;
    n_fail    = 0;
    model_reset();
    #2;
    check_eq("rst_led_a", {28'b0, led_out_a}, 32'd0);
    check_eq("rst_busy_a", {28'b0, busy_a}, 32'd0);

    // Requests toggled while held in reset must have no effect.
    for (int k = 0; k < 10; k++) step(4'($urandom), 4'($urandom));
    presetn = 1'b1;

    // Fade up on channel 0 of A; all channels of B at PRESCALE=1.
    for (int k = 0; k < 32; k++) step(4'b0001, 4'hF);
    highs = 0;
    for (int k = 0; k < 32; k++) begin
      step(4'b0001, 4'hF);
      highs += int'(led_out_a[0]);
    end
    check_eq("duty_at_5", 32'(highs), 32'd10);
    check_eq("b_all_on_busy", {28'b0, busy_b}, 32'd0);
    check_eq("b_all_on_led", {28'b0, led_out_b}, 32'hF);
    for (int k = 0; k < 33; k++) step(4'b0001, 4'hF);
    check_eq("a0_on_busy", {31'b0, busy_a[0]}, 32'd0);
    check_eq("a0_on_led", {31'b0, led_out_a[0]}, 32'd1);

    // Fade down to OFF.
    for (int k = 0; k < 100; k++) step(4'b0000, 4'h0);
    check_eq("a0_off_led", {31'b0, led_out_a[0]}, 32'd0);

    // Ramp everything up, then reverse exactly on a period end.
    for (int k = 0; k < 40; k++) step(4'hF, 4'h0);
    for (int k = 0; k < 32; k++) if ((cyc[0] % 32) != 31) step(cur_a, cur_b);
    check_eq("aligned_to_period_end", cyc[0] % 32, 32'd31);
    step(4'h0, 4'h0);
    check_eq("reversed_busy", {28'b0, busy_a}, 32'hF);
    for (int k = 0; k < 80; k++) step(4'h0, 4'h0);

    // Single-cycle pulse on channel 2.
    step(4'b0100, 4'b0100);
    for (int k = 0; k < 40; k++) step(4'h0, 4'h0);

    // Randomised request activity.
    for (int k = 0; k < 2500; k++) begin
      logic [3:0] na, nb;
      na = cur_a;
      nb = cur_b;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 39) == 0) na[i] = ~na[i];
        if ($urandom_range(0, 39) == 0) nb[i] = ~nb[i];
      end
      step(na, nb);
    end

    // Asynchronous reset in the middle of activity, then again at level 10.
    async_reset_check("areset1");
    for (int k = 0; k < 3; k++) step(4'($urandom), 4'($urandom));
    presetn = 1'b1;
    for (int k = 0; k < 70; k++) step(4'hF, 4'h0);
    check_eq("lvl10_before_reset", 32'(lvl[0][0]), 32'd10);
    async_reset_check("areset2");
    for (int k = 0; k < 5; k++) step(4'($urandom), 4'($urandom));
    presetn = 1'b1;
    for (int k = 0; k < 80; k++) step(4'b0011, 4'b1100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
